// File: rtl/ingress_pkg.sv
// Shared constants for the Avalon ingress FIFO bank: CTRL register bits,
// status field offsets and the saturating drop-counter helper.
package ingress_pkg;

  localparam int unsigned BUS_W            = 32;
  localparam int unsigned CTRL_ADDR        = 0;
  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_CLRDROP_BIT = 1;
  localparam int unsigned STAT_LO_OFS      = 0;
  localparam int unsigned STAT_HI_OFS      = 16;
  localparam int unsigned STAT_FLAG_W      = 8;
  localparam int unsigned DROP_W           = 16;

  typedef logic [DROP_W-1:0] drop_t;

  function automatic drop_t sat_inc(input drop_t v);
    return (v == '1) ? v : v + drop_t'(1);
  endfunction

endpackage

// File: rtl/ingress_fifo.sv
// Single-clock FIFO with registered head output, flush, and full-with-read
// acceptance (a write into a full FIFO succeeds when a read frees a slot).
module ingress_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  input  logic              flush,
  output logic [DATA_W-1:0] q,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  usedw
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              wr_ok, rd_ok;

  always_comb begin
    rd_ok    = rd && !empty_q && !flush;
    wr_ok    = wr && !flush && (!full_q || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        q_d      = mem[rd_ptr_q];
      end
      cnt_d = cnt_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_W'(DEPTH));
  end

  // Storage array carries no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign q     = q_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign usedw = cnt_q;

endmodule

// File: rtl/avalon_ingress_fifo_bank.sv
// Avalon-MM ingress stage: address-selected per-port FIFOs with saturating
// overflow drop counters, software flush and a registered status readback.
module avalon_ingress_fifo_bank
  import ingress_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 3,
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned ADDR_W    = 4,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic                          read,
  input  logic [ADDR_W-1:0]             address,
  input  logic [31:0]                   writedata,
  output logic [31:0]                   readdata,
  input  logic [NUM_PORTS-1:0]          rd_req,
  output logic [NUM_PORTS*DATA_W-1:0]   q,
  output logic [NUM_PORTS-1:0]          empty,
  output logic [NUM_PORTS-1:0]          full,
  output logic [NUM_PORTS*CNT_W-1:0]    usedw
);

  logic                 bus_wr, bus_rd, ctrl_wr, flush, clr_drop;
  logic [NUM_PORTS-1:0] port_wr;
  drop_t                drop_q [NUM_PORTS];
  drop_t                drop_d [NUM_PORTS];
  logic [BUS_W-1:0]     readdata_q, readdata_d;

  always_comb begin
    bus_wr   = chipselect && write;
    bus_rd   = chipselect && read;
    ctrl_wr  = bus_wr && (address == ADDR_W'(CTRL_ADDR));
    flush    = ctrl_wr && writedata[CTRL_FLUSH_BIT];
    clr_drop = ctrl_wr && writedata[CTRL_CLRDROP_BIT];
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      port_wr[p] = bus_wr && (address == ADDR_W'(p + 1));
    end
  end

  for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
    ingress_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (port_wr[p]),
      .wdata (writedata[DATA_W-1:0]),
      .rd    (rd_req[p]),
      .flush (flush),
      .q     (q[p*DATA_W +: DATA_W]),
      .empty (empty[p]),
      .full  (full[p]),
      .usedw (usedw[p*CNT_W +: CNT_W])
    );
  end

  // A write into a full port is only dropped when no dequeue frees a slot.
  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      drop_d[p] = drop_q[p];
      if (clr_drop) begin
        drop_d[p] = '0;
      end else if (port_wr[p] && full[p] && !rd_req[p]) begin
        drop_d[p] = sat_inc(drop_q[p]);
      end
    end
  end

  // Readback samples pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    readdata_d = readdata_q;
    if (bus_rd) begin
      readdata_d = '0;
      if (address == ADDR_W'(CTRL_ADDR)) begin
        readdata_d[STAT_LO_OFS +: STAT_FLAG_W] = STAT_FLAG_W'(full);
        readdata_d[STAT_HI_OFS +: STAT_FLAG_W] = STAT_FLAG_W'(empty);
      end
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (address == ADDR_W'(p + 1)) begin
          readdata_d[STAT_HI_OFS +: DROP_W] = drop_q[p];
          readdata_d[STAT_LO_OFS +: DROP_W] = DROP_W'(usedw[p*CNT_W +: CNT_W]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) drop_q[p] <= '0;
    end else begin
      readdata_q <= readdata_d;
      for (int p = 0; p < int'(NUM_PORTS); p++) drop_q[p] <= drop_d[p];
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_avalon_ingress_fifo_bank.sv
// Randomised and directed bench for avalon_ingress_fifo_bank, checked against
// a queue-based reference model of the ingress stage.
module tb_avalon_ingress_fifo_bank;

  localparam int NP    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              chipselect, write, read;
  logic [AW-1:0]     address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NP-1:0]     rd_req;
  logic [NP*DW-1:0]  q;
  logic [NP-1:0]     empty, full;
  logic [NP*CW-1:0]  usedw;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq [NP][$];
  int            mdrop [NP];
  logic [DW-1:0] mhead [NP];
  logic [31:0]   mrd;

  avalon_ingress_fifo_bank #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .rd_req     (rd_req),
    .q          (q),
    .empty      (empty),
    .full       (full),
    .usedw      (usedw)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] exp_empty();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = (mq[p].size() == 0);
    return v;
  endfunction

  function automatic logic [NP-1:0] exp_full();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = (mq[p].size() == DEPTH);
    return v;
  endfunction

  function automatic logic [NP*CW-1:0] exp_usedw();
    logic [NP*CW-1:0] v;
    for (int p = 0; p < NP; p++) v[p*CW +: CW] = CW'(mq[p].size());
    return v;
  endfunction

  function automatic logic [NP*DW-1:0] exp_q();
    logic [NP*DW-1:0] v;
    for (int p = 0; p < NP; p++) v[p*DW +: DW] = mhead[p];
    return v;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      mdrop[p] = 0;
      mhead[p] = '0;
    end
    mrd = '0;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = '0;
    writedata  = '0;
    rd_req     = '0;
  endtask

  // Apply the current inputs to the model, then advance one clock.
  task automatic step();
    logic [31:0] nrd;
    int          a;
    bit          fl, clr;
    nrd = mrd;
    a   = int'(address);
    fl  = 1'b0;
    clr = 1'b0;
    if (chipselect && read) begin
      nrd = '0;
      if (a == 0) begin
        nrd[7:0]   = 8'(exp_full());
        nrd[23:16] = 8'(exp_empty());
      end else if (a <= NP) begin
        nrd = {16'(mdrop[a-1]), 16'(mq[a-1].size())};
      end
    end
    if (chipselect && write && a == 0) begin
      fl  = writedata[0];
      clr = writedata[1];
    end
    for (int p = 0; p < NP; p++) begin
      if (fl) mq[p].delete();
      if (clr) mdrop[p] = 0;
      if (!fl && rd_req[p] && mq[p].size() > 0) mhead[p] = mq[p].pop_front();
      if (chipselect && write && a == p + 1) begin
        if (mq[p].size() < DEPTH) mq[p].push_back(writedata[DW-1:0]);
        else if (mdrop[p] < 65535) mdrop[p]++;
      end
    end
    mrd = nrd;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = AW'(a); writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input int a);
    chipselect = 1'b1; write = 1'b0; read = 1'b1;
    address = AW'(a);
    step();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    checks++;
    if (q !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++;
    if (empty !== 3'b111 || full !== 3'b000) begin
      failures++; $display("FAIL reset_flags empty=%b full=%b exp 111/000", empty, full);
    end
    checks++;
    if (usedw !== '0) begin failures++; $display("FAIL reset_usedw got=%h exp=0", usedw); end
  endtask

  task automatic test_single_write();
    bus_write(2, 32'h0000_00A5);
    checks++;
    if (empty[1] !== 1'b0 || usedw !== exp_usedw()) begin
      failures++; $display("FAIL single_write_flags empty=%b usedw=%h exp_usedw=%h", empty, usedw, exp_usedw());
    end
    bus_read(2);
    checks++;
    if (readdata !== 32'h0000_0001) begin
      failures++; $display("FAIL single_write_read got=%h exp=%h", readdata, 32'h0000_0001);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] first;
    first = DW'($urandom);
    for (int i = 0; i < DEPTH + 3; i++) bus_write(1, (i == 0) ? first : $urandom);
    checks++;
    if (full[0] !== 1'b1 || usedw[CW-1:0] !== CW'(DEPTH)) begin
      failures++; $display("FAIL overflow_full full0=%b usedw0=%0d exp 1/%0d", full[0], usedw[CW-1:0], DEPTH);
    end
    bus_read(1);
    checks++;
    if (readdata[31:16] !== 16'd3 || readdata !== mrd) begin
      failures++; $display("FAIL overflow_drop got=%h exp=%h", readdata, mrd);
    end
    rd_req = 3'b001;
    step();
    rd_req = '0;
    checks++;
    if (q[DW-1:0] !== first) begin
      failures++; $display("FAIL overflow_head got=%h exp=%h", q[DW-1:0], first);
    end
  endtask

  task automatic test_full_simul();
    bus_write(1, $urandom);
    checks++;
    if (full[0] !== 1'b1) begin failures++; $display("FAIL simul_prefill full0=%b exp=1", full[0]); end
    chipselect = 1'b1; write = 1'b1; address = AW'(1); writedata = $urandom;
    rd_req = 3'b001;
    step();
    idle();
    checks++;
    if (usedw[CW-1:0] !== CW'(DEPTH) || full[0] !== 1'b1) begin
      failures++; $display("FAIL simul_usedw got=%0d exp=%0d", usedw[CW-1:0], DEPTH);
    end
    bus_read(1);
    checks++;
    if (readdata !== {16'd3, 16'(DEPTH)}) begin
      failures++; $display("FAIL simul_drop got=%h exp=%h", readdata, {16'd3, 16'(DEPTH)});
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_req = 3'b001;
      step();
      checks++;
      if (q !== exp_q() || usedw !== exp_usedw()) begin
        failures++; $display("FAIL simul_drain%0d q=%h exp=%h usedw=%h exp=%h", i, q, exp_q(), usedw, exp_usedw());
      end
    end
    rd_req = '0;
  endtask

  task automatic test_flush();
    logic [NP*DW-1:0] q_before;
    for (int i = 0; i < 2; i++) bus_write(1, $urandom);
    for (int i = 0; i < DEPTH + 1; i++) bus_write(3, $urandom);
    q_before = q;
    chipselect = 1'b1; write = 1'b1; address = '0; writedata = 32'h1;
    rd_req = 3'b111;
    step();
    idle();
    checks++;
    if (usedw !== '0 || empty !== 3'b111 || full !== 3'b000) begin
      failures++; $display("FAIL flush_state usedw=%h empty=%b full=%b", usedw, empty, full);
    end
    checks++;
    if (q !== q_before) begin failures++; $display("FAIL flush_q got=%h exp=%h", q, q_before); end
    bus_read(3);
    checks++;
    if (readdata !== 32'h0001_0000) begin
      failures++; $display("FAIL flush_drop_kept got=%h exp=%h", readdata, 32'h0001_0000);
    end
    bus_write(0, 32'h2);
    bus_read(1);
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL clrdrop_p0 got=%h exp=0", readdata); end
    bus_read(3);
    checks++;
    if (readdata !== mrd || mrd !== 32'h0) begin
      failures++; $display("FAIL clrdrop_p2 got=%h exp=%h", readdata, mrd);
    end
  endtask

  task automatic test_reset_mid();
    bus_write(2, $urandom);
    bus_write(2, $urandom);
    bus_read(2);
    chipselect = 1'b1; write = 1'b1; address = AW'(2); writedata = $urandom;
    rd_req = 3'b010;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (q !== '0 || empty !== 3'b111 || full !== '0 || usedw !== '0 || readdata !== '0) begin
      failures++; $display("FAIL reset_mid q=%h empty=%b full=%b usedw=%h rd=%h", q, empty, full, usedw, readdata);
    end
    idle();
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_read(0);
    checks++;
    if (readdata !== 32'h0007_0000) begin
      failures++; $display("FAIL reset_mid_status got=%h exp=%h", readdata, 32'h0007_0000);
    end
  endtask

  task automatic test_unmapped();
    logic [DW-1:0] q2;
    bus_write(1, $urandom);
    bus_write(NP + 1, $urandom);
    checks++;
    if (usedw !== exp_usedw() || empty !== 3'b110) begin
      failures++; $display("FAIL unmapped_write usedw=%h exp=%h empty=%b", usedw, exp_usedw(), empty);
    end
    bus_read(1);
    bus_read(NP + 1);
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", readdata); end
    q2 = q[2*DW +: DW];
    rd_req = 3'b100;
    step();
    rd_req = '0;
    checks++;
    if (q[2*DW +: DW] !== q2 || usedw[2*CW +: CW] !== '0) begin
      failures++; $display("FAIL empty_rd q2=%h exp=%h usedw2=%0d", q[2*DW +: DW], q2, usedw[2*CW +: CW]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write      = $urandom_range(0, 1);
      read       = $urandom_range(0, 1);
      address    = AW'($urandom_range(0, NP + 2));
      writedata  = $urandom;
      if (address == '0 && $urandom_range(0, 7) != 0) writedata[1:0] = 2'b00;
      rd_req     = NP'($urandom);
      step();
      checks++;
      if (readdata !== mrd || q !== exp_q() || empty !== exp_empty() ||
          full !== exp_full() || usedw !== exp_usedw()) begin
        failures++;
        $display("FAIL random%0d rd=%h/%h q=%h/%h empty=%b/%b full=%b/%b usedw=%h/%h", i,
                 readdata, mrd, q, exp_q(), empty, exp_empty(), full, exp_full(), usedw, exp_usedw());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_full_simul();
    test_flush();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
